jedro_1_mem_arbiter: RTL and testbench

//  Sits directly downstream of the core's instruction and data bus ports and

---
 rtl/jedro_1_mem_arbiter_if.sv | 32 +++
 rtl/jedro_1_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_jedro_1_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_mem_arbiter_if.sv
// jedro_1 memory bus: request/response handshake bundle.
// master drives requests, slave answers them.
interface jedro_1_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [3:0]            req_strobe;
  logic                  req_write;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_valid;
  logic                  rsp_ready;

  modport master (
    output req_addr, req_data, req_strobe,
    output req_write, req_valid,
    input  req_ready,
    input  rsp_data, rsp_err, rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  req_addr, req_data, req_strobe,
    input  req_write, req_valid,
    output req_ready,
    output rsp_data, rsp_err, rsp_valid,
    input  rsp_ready
  );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1 instr/data -> single memory port arbiter.
// Round-robin grant, in-order response routing via route FIFO.
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  jedro_1_mem_arbiter_if.slave  instr,
  jedro_1_mem_arbiter_if.slave  data,
  jedro_1_mem_arbiter_if.master mem,
  output logic                        unexp_rsp_o
);

  localparam int PTR_W =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(MAX_OUTSTANDING);
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCK_I,
    S_LOCK_D
  } lock_e;

  lock_e                 state_q, state_d;
  logic                  rr_last_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] route_q;
  logic                  unexp_q;

  logic                  sel;
  logic                  gnt_v;
  logic                  avail;
  logic                  mem_v;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  head;
  logic [DATA_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign avail = ~rst_i && (count_q != CNT_FULL);
  assign mem_v = avail & gnt_v;
  assign push  = mem_v & mem.req_ready;
  assign empty = (count_q == '0);
  assign head  = route_q[rptr_q];
  assign pop   = mem.rsp_valid & mem.rsp_ready & ~empty;

  // Grant select: frozen while locked, else round-robin.
  always_comb begin
    sel   = SIDE_I;
    gnt_v = 1'b0;
    unique case (state_q)
      S_LOCK_I: begin
        sel   = SIDE_I;
        gnt_v = instr.req_valid;
      end
      S_LOCK_D: begin
        sel   = SIDE_D;
        gnt_v = data.req_valid;
      end
      default: begin
        unique case (1'b1)
          instr.req_valid && data.req_valid: begin
            sel   = ~rr_last_q;
            gnt_v = 1'b1;
          end
          instr.req_valid && !data.req_valid: begin
            sel   = SIDE_I;
            gnt_v = 1'b1;
          end
          !instr.req_valid && data.req_valid: begin
            sel   = SIDE_D;
            gnt_v = 1'b1;
          end
          default: begin
            sel   = SIDE_I;
            gnt_v = 1'b0;
          end
        endcase
      end
    endcase
  end

  // Request mux: zero-cycle pass-through of granted side.
  always_comb begin
    addr_mux  = sel ? data.req_addr : instr.req_addr;
    wdata_mux = sel ? data.req_data : instr.req_data;
    mem.req_addr    = addr_mux;
    mem.req_data    = wdata_mux;
    mem.req_strobe  = sel ? data.req_strobe
                          : instr.req_strobe;
    mem.req_write   = sel ? data.req_write
                          : instr.req_write;
    mem.req_valid   = mem_v;
    instr.req_ready = mem_v & (sel == SIDE_I)
                    & mem.req_ready;
    data.req_ready  = mem_v & (sel == SIDE_D)
                    & mem.req_ready;
  end

  // Lock next state: hold grant across a stalled request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_v && !mem.req_ready)
          state_d = sel ? S_LOCK_D : S_LOCK_I;
      end
      S_LOCK_I, S_LOCK_D: begin
        if (push) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response steering by route FIFO head; drop when empty.
  always_comb begin
    instr.rsp_valid = 1'b0;
    data.rsp_valid  = 1'b0;
    mem.rsp_ready   = 1'b0;
    instr.rsp_data  = mem.rsp_data;
    instr.rsp_err   = mem.rsp_err;
    data.rsp_data   = mem.rsp_data;
    data.rsp_err    = mem.rsp_err;
    if (!rst_i) begin
      if (empty) begin
        mem.rsp_ready = 1'b1;
      end else if (head == SIDE_D) begin
        data.rsp_valid = mem.rsp_valid;
        mem.rsp_ready  = data.rsp_ready;
      end else begin
        instr.rsp_valid = mem.rsp_valid;
        mem.rsp_ready   = instr.rsp_ready;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Route FIFO, occupancy and round-robin history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      route_q   <= '0;
      rr_last_q <= SIDE_D;
    end else begin
      if (push) begin
        route_q[wptr_q] <= sel;
        wptr_q          <= ptr_inc(wptr_q);
        rr_last_q       <= sel;
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for responses with no route.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     unexp_q <= 1'b0;
    else if (empty && mem.rsp_valid) unexp_q <= 1'b1;
  end

  assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: cycle table plus
// route scoreboard and a reset-discard sequence.
module tb_jedro_1_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic unexp;

  always #5 clk = ~clk;

  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) ibus ();
  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) dbus ();
  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) mbus ();

  jedro_1_mem_arbiter #(
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .instr      (ibus),
    .data       (dbus),
    .mem        (mbus),
    .unexp_rsp_o(unexp)
  );

  // in : {rst, i_v, d_v, mem_rdy, rsp_v, i_rrdy, d_rrdy}
  // exp: {mem_v, i_rdy, d_rdy, mem_rrdy, i_rv, d_rv, unexp}
  typedef struct packed {
    logic [6:0] in;
    logic       side;
    logic [6:0] exp;
    logic [7:0] rdat;
  } vec_t;

  localparam int NV = 35;
  vec_t tab [NV];
  logic sbq [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [6:0]  act;
    logic [68:0] pay, epay;
    logic [31:0] ia, da;
    logic        s;
    @(posedge clk);
    #1;
    ia = 32'h1000_0000 + 32'(idx);
    da = 32'h2000_0000 + 32'(idx);
    rst                = v.in[6];
    ibus.req_valid     = v.in[5];
    dbus.req_valid     = v.in[4];
    mbus.req_ready     = v.in[3];
    mbus.rsp_valid     = v.in[2];
    ibus.rsp_ready     = v.in[1];
    dbus.rsp_ready     = v.in[0];
    ibus.req_addr      = ia;
    ibus.req_data      = ~ia;
    ibus.req_strobe    = 4'h3;
    ibus.req_write     = 1'b0;
    dbus.req_addr      = da;
    dbus.req_data      = da ^ 32'h5555_5555;
    dbus.req_strobe    = 4'hC;
    dbus.req_write     = 1'b1;
    mbus.rsp_data      = {24'h0, v.rdat};
    mbus.rsp_err       = v.rdat[0];
    @(negedge clk);
    act = {mbus.req_valid, ibus.req_ready,
           dbus.req_ready, mbus.rsp_ready,
           ibus.rsp_valid, dbus.rsp_valid, unexp};
    chk("ctl", idx, 128'(act), 128'(v.exp));
    if (v.exp[6]) begin
      pay  = {mbus.req_addr, mbus.req_data,
              mbus.req_strobe, mbus.req_write};
      epay = v.side
           ? {da, da ^ 32'h5555_5555, 4'hC, 1'b1}
           : {ia, ~ia, 4'h3, 1'b0};
      chk("req_payload", idx, 128'(pay), 128'(epay));
    end
    if (v.in[6]) begin
      sbq.delete();
    end else begin
      if (v.in[2] && v.exp[3] && sbq.size() > 0) begin
        s = sbq.pop_front();
        if (s)
          chk("rsp_route_d", idx,
              128'({dbus.rsp_valid, ibus.rsp_valid,
                    dbus.rsp_data, dbus.rsp_err}),
              128'({2'b10, 24'h0, v.rdat, v.rdat[0]}));
        else
          chk("rsp_route_i", idx,
              128'({ibus.rsp_valid, dbus.rsp_valid,
                    ibus.rsp_data, ibus.rsp_err}),
              128'({2'b10, 24'h0, v.rdat, v.rdat[0]}));
      end
      if (v.exp[6] && v.in[3]) sbq.push_back(v.side);
    end
  endtask

  initial begin
    rst            = 1'b1;
    ibus.req_valid = 1'b0;
    dbus.req_valid = 1'b0;
    mbus.req_ready = 1'b0;
    mbus.rsp_valid = 1'b0;
    ibus.rsp_ready = 1'b0;
    dbus.rsp_ready = 1'b0;
    ibus.req_addr  = '0;
    ibus.req_data  = '0;
    ibus.req_strobe = '0;
    ibus.req_write = 1'b0;
    dbus.req_addr  = '0;
    dbus.req_data  = '0;
    dbus.req_strobe = '0;
    dbus.req_write = 1'b0;
    mbus.rsp_data  = '0;
    mbus.rsp_err   = 1'b0;

    // reset with everything valid, then lone instr
    tab[0]  = '{7'b1111111, 1'b0, 7'b0000000, 8'h00};
    tab[1]  = '{7'b0101011, 1'b0, 7'b1101000, 8'h00};
    tab[2]  = '{7'b0001111, 1'b0, 7'b0001100, 8'h11};
    // conflict alternation from reset: I,D,I,D
    tab[3]  = '{7'b1000000, 1'b0, 7'b0000000, 8'h00};
    tab[4]  = '{7'b0111011, 1'b0, 7'b1101000, 8'h00};
    tab[5]  = '{7'b0111111, 1'b1, 7'b1011100, 8'h21};
    tab[6]  = '{7'b0111111, 1'b0, 7'b1101010, 8'h22};
    tab[7]  = '{7'b0111111, 1'b1, 7'b1011100, 8'h23};
    tab[8]  = '{7'b0001111, 1'b0, 7'b0001010, 8'h24};
    // lock on stalled data request
    tab[9]  = '{7'b0010011, 1'b1, 7'b1001000, 8'h00};
    tab[10] = '{7'b0110011, 1'b1, 7'b1001000, 8'h00};
    tab[11] = '{7'b0110011, 1'b1, 7'b1001000, 8'h00};
    tab[12] = '{7'b0111011, 1'b1, 7'b1011000, 8'h00};
    tab[13] = '{7'b0001111, 1'b0, 7'b0001010, 8'h31};
    // fill to four, block, pop one, accept fifth
    tab[14] = '{7'b0111011, 1'b0, 7'b1101000, 8'h00};
    tab[15] = '{7'b0111011, 1'b1, 7'b1011000, 8'h00};
    tab[16] = '{7'b0111011, 1'b0, 7'b1101000, 8'h00};
    tab[17] = '{7'b0111011, 1'b1, 7'b1011000, 8'h00};
    tab[18] = '{7'b0111011, 1'b0, 7'b0001000, 8'h00};
    tab[19] = '{7'b0111111, 1'b0, 7'b0001100, 8'hA0};
    tab[20] = '{7'b0111011, 1'b0, 7'b1101000, 8'h00};
    tab[21] = '{7'b0001111, 1'b0, 7'b0001010, 8'hA1};
    tab[22] = '{7'b0001111, 1'b0, 7'b0001100, 8'hA2};
    tab[23] = '{7'b0001111, 1'b0, 7'b0001010, 8'hA3};
    tab[24] = '{7'b0001111, 1'b0, 7'b0001100, 8'hA4};
    // response backpressure on instr head
    tab[25] = '{7'b0101011, 1'b0, 7'b1101000, 8'h00};
    tab[26] = '{7'b0001101, 1'b0, 7'b0000100, 8'h51};
    tab[27] = '{7'b0001101, 1'b0, 7'b0000100, 8'h52};
    tab[28] = '{7'b0001111, 1'b0, 7'b0001100, 8'h53};
    // unexpected response is sticky until reset
    tab[29] = '{7'b0001111, 1'b0, 7'b0001000, 8'h61};
    tab[30] = '{7'b0000011, 1'b0, 7'b0001001, 8'h00};
    tab[31] = '{7'b0101011, 1'b0, 7'b1101001, 8'h00};
    tab[32] = '{7'b0001111, 1'b0, 7'b0001101, 8'h62};
    tab[33] = '{7'b1000000, 1'b0, 7'b0000000, 8'h00};
    tab[34] = '{7'b0000011, 1'b0, 7'b0001000, 8'h00};

    for (int i = 0; i < NV; i++) step(tab[i], i);

    // reset mid-transaction: route dropped, reply unexpected
    step('{7'b0101011, 1'b0, 7'b1101000, 8'h00}, 100);
    step('{7'b1000000, 1'b0, 7'b0000000, 8'h00}, 101);
    step('{7'b0001111, 1'b0, 7'b0001000, 8'h77}, 102);
    step('{7'b0000011, 1'b0, 7'b0001001, 8'h00}, 103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
